// File: rtl/rr_arb21.sv
// Two-input round-robin arbiter feeding a single registered output stage.
// Ties go to the channel that did not win the previous accepted transfer.
module rr_arb21 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel
);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_data_q,  y_data_d;
    src_e             sel_q,      sel_d;
    src_e             last_sel_q, last_sel_d;

    logic can_load;
    src_e gnt;
    logic accept;

    // rst_n gates the readies so no handshake is advertised while in reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        can_load = rst_n && (!y_valid_q || y_ready);
        gnt      = SRC_A;
        if (a_valid && b_valid) begin
            gnt = (last_sel_q == SRC_A) ? SRC_B : SRC_A;
        end else if (b_valid) begin
            gnt = SRC_B;
        end
    end

    assign a_ready = can_load && a_valid && (gnt == SRC_A);
    assign b_ready = can_load && b_valid && (gnt == SRC_B);
    assign accept  = a_ready || b_ready;

    always_comb begin
        y_valid_d  = y_valid_q;
        y_data_d   = y_data_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        if (accept) begin
            y_valid_d  = 1'b1;
            y_data_d   = (gnt == SRC_B) ? b_data : a_data;
            sel_d      = gnt;
            last_sel_d = gnt;
        end else if (y_ready) begin
            // Drained with nothing to replace it: data and sel keep their last values.
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: last_sel resets to B so that A wins the first tie after reset.
        if (!rst_n) begin
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            sel_q      <= SRC_A;
            last_sel_q <= SRC_B;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
            y_valid_q  <= y_valid_d;
            y_data_q   <= y_data_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_rr_arb21.sv
// Self-checking bench for rr_arb21: directed scenarios plus a random stress run,
// all traffic checked against a queue of expected {sel, data} words.
module tb_rr_arb21;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_ready;
    logic             sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state kept by the bench.
    logic             m_yv;
    logic             m_last;
    logic [WIDTH:0]   sb_q[$];
    int               a_wait;
    int               b_wait;

    rr_arb21 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_yv   = 1'b0;
        m_last = 1'b1;
        sb_q.delete();
        a_wait = 0;
        b_wait = 0;
    endtask

    // One clock of traffic: drive at negedge, check handshakes, update the model, return just after posedge.
    task automatic cycle(input logic av, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [WIDTH-1:0] bd, input logic yr);
        logic           can, ga, gb;
        logic [WIDTH:0] exp_w;
        @(negedge clk);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        #1;
        can = !m_yv || yr;
        gb  = bv && (!av || (m_last == 1'b0));
        ga  = av && !gb;
        n_cmp++;
        if (a_ready !== (can && ga) || b_ready !== (can && gb)) begin
            n_bad++;
            $display("FAIL ready: got a=%b b=%b expected a=%b b=%b", a_ready, b_ready, can && ga, can && gb);
        end
        n_cmp++;
        if ((a_ready && b_ready) !== 1'b0) begin
            n_bad++;
            $display("FAIL both_ready: a_ready=%b b_ready=%b expected not both 1", a_ready, b_ready);
        end
        n_cmp++;
        if (y_valid !== m_yv) begin
            n_bad++;
            $display("FAIL y_valid: got %b expected %b", y_valid, m_yv);
        end
        if (y_valid === 1'b1 && yr) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty: got output sel=%b data=%h expected no output", sel, y_data);
            end else begin
                exp_w = sb_q.pop_front();
                if ({sel, y_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL sb_word: got sel=%b data=%h expected sel=%b data=%h",
                             sel, y_data, exp_w[WIDTH], exp_w[WIDTH-1:0]);
                end
            end
        end
        // Starvation: a waiting channel may see at most one grant to the other side.
        if (a_valid && b_valid && b_ready) begin
            a_wait++;
            n_cmp++;
            if (a_wait > 1) begin
                n_bad++;
                $display("FAIL starve_a: got %0d grants to B while A waited expected <= 1", a_wait);
            end
        end else if (!a_valid || a_ready) begin
            a_wait = 0;
        end
        if (b_valid && a_valid && a_ready) begin
            b_wait++;
            n_cmp++;
            if (b_wait > 1) begin
                n_bad++;
                $display("FAIL starve_b: got %0d grants to A while B waited expected <= 1", b_wait);
            end
        end else if (!b_valid || b_ready) begin
            b_wait = 0;
        end
        if (can && (ga || gb)) begin
            sb_q.push_back(gb ? {1'b1, bd} : {1'b0, ad});
            m_yv   = 1'b1;
            m_last = gb;
        end else if (yr) begin
            m_yv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; y_ready = 1'b1;
        model_reset();
        #3;
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (y_valid !== 1'b0 || y_data !== 8'h00 || sel !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b d=%h s=%b expected 0 00 0", y_valid, y_data, sel);
        end
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_clk: got a=%b b=%b expected 0 0", a_ready, b_ready);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tie();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
            n_cmp++;
            if (y_valid !== 1'b1 || sel !== 1'(i % 2) || y_data !== ((i % 2) ? 8'h22 : 8'h11)) begin
                n_bad++;
                $display("FAIL tie_%0d: got v=%b s=%b d=%h expected v=1 s=%0d d=%h",
                         i, y_valid, sel, y_data, i % 2, (i % 2) ? 8'h22 : 8'h11);
            end
        end
    endtask

    task automatic test_single();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
            n_cmp++;
            if (y_data !== 8'h5A || sel !== 1'b1 || a_ready !== 1'b0 || y_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL single_%0d: got d=%h s=%b a_ready=%b v=%b expected d=5a s=1 a_ready=0 v=1",
                         i, y_data, sel, a_ready, y_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        n_cmp++;
        if (y_data !== 8'h11 || sel !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_load: got d=%h s=%b expected d=11 s=0", y_data, sel);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
            n_cmp++;
            if (y_data !== 8'h11 || sel !== 1'b0 || y_valid !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got d=%h s=%b v=%b a=%b b=%b expected d=11 s=0 v=1 a=0 b=0",
                         i, y_data, sel, y_valid, a_ready, b_ready);
            end
        end
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        n_cmp++;
        if (y_data !== 8'h22 || sel !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: got d=%h s=%b expected d=22 s=1", y_data, sel);
        end
    endtask

    task automatic test_drain();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (y_valid !== 1'b1 || y_data !== 8'h11) begin
            n_bad++;
            $display("FAIL drain_load: got v=%b d=%h expected v=1 d=11", y_valid, y_data);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (y_valid !== 1'b0 || y_data !== 8'h11 || sel !== 1'b0) begin
                n_bad++;
                $display("FAIL drain_%0d: got v=%b d=%h s=%b expected v=0 d=11 s=0", i, y_valid, y_data, sel);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
        #2;
        a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (y_valid !== 1'b0 || y_data !== 8'h00 || sel !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset: got v=%b d=%h s=%b a=%b b=%b expected 0 00 0 0 0",
                     y_valid, y_data, sel, a_ready, b_ready);
        end
        model_reset();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
        n_cmp++;
        if (y_data !== 8'h44 || sel !== 1'b0 || y_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_tie: got d=%h s=%b v=%b expected d=44 s=0 v=1", y_data, sel, y_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d words still pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
